// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared types and helpers for the RV32 load/store unit.
//   XLEN/BE_W        datapath width (32 only) and byte enables per word
//   t_m / t_mt       decoded memory function and access type from the datapath
//   t_lsu_state      LSU FSM states
//   t_exc_cause      cause codes reported on dp_exc_cause
//   mt_be            byte-enable mask for a type at a byte lane
//   mt_legal         access types the LSU can perform
//   mt_align         address rounded down to the natural size of the type
//   mt_misaligned    true when the address is not naturally aligned for the type
package rv32_lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } t_m;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } t_mt;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_REQ  = 3'd1,
    LSU_WAIT = 3'd2,
    LSU_DONE = 3'd3,
    LSU_EXC  = 3'd4
  } t_lsu_state;

  typedef enum logic [1:0] {
    EXC_LD_MA   = 2'd0,
    EXC_ST_MA   = 2'd1,
    EXC_ILL_TYP = 2'd2
  } t_exc_cause;

  function automatic logic [BE_W-1:0] mt_be(input t_mt typ, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    case (typ)
      MT_B, MT_BU: be = 4'b0001 << lane;
      MT_H, MT_HU: be = 4'b0011 << {lane[1], 1'b0};
      MT_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic mt_legal(input t_mt typ);
    logic ok;
    case (typ)
      MT_B, MT_H, MT_W, MT_BU, MT_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] mt_align(input t_mt typ, input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] a;
    case (typ)
      MT_H, MT_HU: a = {addr[XLEN-1:1], 1'b0};
      MT_W:        a = {addr[XLEN-1:2], 2'b00};
      default:     a = addr;
    endcase
    return a;
  endfunction

  function automatic logic mt_misaligned(input t_mt typ, input logic [1:0] lane);
    logic ma;
    case (typ)
      MT_H, MT_HU: ma = lane[0];
      MT_W:        ma = (lane != 2'b00);
      default:     ma = 1'b0;
    endcase
    return ma;
  endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: req/resp data-memory port.
//   master (LSU):    drives mem_req_valid/wr/addr/wdata/be; samples ready and response
//   slave  (memory): drives mem_req_ready, mem_resp_valid, mem_resp_data
interface rv32_lsu_if;
  import rv32_lsu_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wr;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [BE_W-1:0] mem_req_be;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/rv32_lsu_align.sv
// rv32_lsu_align: combinational lane steering for the LSU.
//   st_typ/st_lane/st_data -> st_be, st_wdata : byte enables and lane-replicated store data
//   ld_typ/ld_lane/ld_raw  -> ld_data         : lane-selected, sign/zero-extended load data
module rv32_lsu_align
  import rv32_lsu_pkg::*;
(
  input  t_mt             st_typ,
  input  logic [1:0]      st_lane,
  input  logic [XLEN-1:0] st_data,
  output logic [BE_W-1:0] st_be,
  output logic [XLEN-1:0] st_wdata,
  input  t_mt             ld_typ,
  input  logic [1:0]      ld_lane,
  input  logic [XLEN-1:0] ld_raw,
  output logic [XLEN-1:0] ld_data
);

  logic [15:0] ld_half_s;
  logic [7:0]  ld_byte_s;

  // Store side: replicate the right-justified datum across every lane it could land in.
  always_comb begin
    st_be = mt_be(st_typ, st_lane);
    case (st_typ)
      MT_B, MT_BU: st_wdata = {4{st_data[7:0]}};
      MT_H, MT_HU: st_wdata = {2{st_data[15:0]}};
      default:     st_wdata = st_data;
    endcase
  end

  // Load side: pick the addressed halfword/byte, then extend by type.
  always_comb begin
    ld_half_s = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_byte_s = ld_lane[0] ? ld_half_s[15:8] : ld_half_s[7:0];
    case (ld_typ)
      MT_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      MT_BU:   ld_data = {24'h000000, ld_byte_s};
      MT_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      MT_HU:   ld_data = {16'h0000, ld_half_s};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// rv32_lsu: load/store unit between the single-stage datapath and a req/resp data memory.
//   clk, rst_n                 clock, asynchronous active-low reset
//   dp_mem_en/fcn/typ/addr/wdata  decoded memory op from execute (held while dp_stall=1)
//   dp_rdata                   extended load data, valid in DONE
//   dp_stall                   freezes the core until the access completes
//   dp_exc, dp_exc_cause       one-cycle exception pulse and cause
//   mem (rv32_lsu_if.master)   word-aligned request with byte enables, response/ack
// FSM: IDLE->REQ->WAIT->DONE->IDLE, or IDLE->EXC->IDLE for rejected accesses.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses raise an exception instead
// of being aligned down to their natural size.
module rv32_lsu
  import rv32_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dp_mem_en,
  input  t_m              dp_mem_fcn,
  input  t_mt             dp_mem_typ,
  input  logic [XLEN-1:0] dp_addr,
  input  logic [XLEN-1:0] dp_wdata,
  output logic [XLEN-1:0] dp_rdata,
  output logic            dp_stall,
  output logic            dp_exc,
  output logic [1:0]      dp_exc_cause,
  rv32_lsu_if.master      mem
);

  t_lsu_state      state_q, state_d;
  logic            req_valid_q, req_valid_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0] be_q, be_d;
  t_mt             typ_q, typ_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            exc_q, exc_d;
  t_exc_cause      cause_q, cause_d;

  logic [XLEN-1:0] eff_addr_s;
  logic            misalign_s;
  logic [BE_W-1:0] al_be_s;
  logic [XLEN-1:0] al_wdata_s;
  logic [XLEN-1:0] ld_data_s;

  // Effective address and misalignment decision for the op waiting in IDLE.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = mt_misaligned(dp_mem_typ, dp_addr[1:0]);
    eff_addr_s = dp_addr;
`else
    misalign_s = 1'b0;
    eff_addr_s = mt_align(dp_mem_typ, dp_addr);
`endif
  end

  rv32_lsu_align u_align (
    .st_typ   (dp_mem_typ),
    .st_lane  (eff_addr_s[1:0]),
    .st_data  (dp_wdata),
    .st_be    (al_be_s),
    .st_wdata (al_wdata_s),
    .ld_typ   (typ_q),
    .ld_lane  (lane_q),
    .ld_raw   (mem.mem_resp_data),
    .ld_data  (ld_data_s)
  );

  // Next-state and register updates; payload is latched once in IDLE and held until accepted.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    typ_d       = typ_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    exc_d       = 1'b0;
    cause_d     = cause_q;
    case (state_q)
      LSU_IDLE: begin
        if (dp_mem_en) begin
          if (!mt_legal(dp_mem_typ)) begin
            state_d = LSU_EXC;
            exc_d   = 1'b1;
            cause_d = EXC_ILL_TYP;
          end else if (misalign_s) begin
            state_d = LSU_EXC;
            exc_d   = 1'b1;
            cause_d = (dp_mem_fcn == M_XWR) ? EXC_ST_MA : EXC_LD_MA;
          end else begin
            state_d     = LSU_REQ;
            req_valid_d = 1'b1;
            wr_d        = (dp_mem_fcn == M_XWR);
            addr_d      = {eff_addr_s[XLEN-1:2], 2'b00};
            wdata_d     = al_wdata_s;
            be_d        = al_be_s;
            typ_d       = dp_mem_typ;
            lane_d      = eff_addr_s[1:0];
          end
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (mem.mem_req_ready) begin
          state_d     = LSU_WAIT;
          req_valid_d = 1'b0;
        end else begin
          state_d = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        if (mem.mem_resp_valid) begin
          state_d = LSU_DONE;
          // Store acks carry no data; keep the last load result.
          rdata_d = wr_q ? rdata_q : ld_data_s;
        end else begin
          state_d = LSU_WAIT;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      LSU_EXC:  state_d = LSU_IDLE;
      default: begin
        state_d     = LSU_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and request/response registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      req_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
      typ_q       <= MT_X;
      lane_q      <= 2'b00;
      rdata_q     <= 32'h0000_0000;
      exc_q       <= 1'b0;
      cause_q     <= EXC_LD_MA;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      typ_q       <= typ_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_wr    = wr_q;
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_be    = be_q;
  assign dp_rdata          = rdata_q;
  assign dp_exc            = exc_q;
  assign dp_exc_cause      = cause_q;
  assign dp_stall          = dp_mem_en & (state_q inside {LSU_IDLE, LSU_REQ, LSU_WAIT});

endmodule
